// File: rtl/ppu_timing_ctrl.sv
// LCD dot/line timing, mode decode, VRAM/OAM locks, LCDC/STAT/LY/LYC registers and V-Blank/STAT interrupts.
// Define PPU_STAT_BLOCKING_EN to merge the four STAT sources into one line with a single edge detector.
module ppu_timing_ctrl #(
    parameter int PIXELS    = 456,
    parameter int LINES     = 154,
    parameter int VACTIVE   = 144,
    parameter int OAM_DOTS  = 80,
    parameter int XFER_DOTS = 172,
    parameter int DIV       = 8,
    parameter int LINE_W    = 8,
    parameter int DOT_W     = 9
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [15:0]       A,
    input  logic [7:0]        Di,
    output logic [7:0]        Do,
    input  logic              rd_n,
    input  logic              wr_n,
    input  logic              cs,
    input  logic [3:0]        xfer_extra,
    output logic              int_vblank_req,
    input  logic              int_vblank_ack,
    output logic              int_lcdc_req,
    input  logic              int_lcdc_ack,
    output logic              dot_en,
    output logic [LINE_W-1:0] line_count,
    output logic [DOT_W-1:0]  pixel_count,
    output logic [1:0]        mode,
    output logic              oam_lock,
    output logic              vram_lock
);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [15:0] ADDR_LCDC = 16'hFF40;
    localparam logic [15:0] ADDR_STAT = 16'hFF41;
    localparam logic [15:0] ADDR_LY   = 16'hFF44;
    localparam logic [15:0] ADDR_LYC  = 16'hFF45;

    typedef enum logic [1:0] {
        MODE_HBLANK = 2'd0,
        MODE_VBLANK = 2'd1,
        MODE_OAM    = 2'd2,
        MODE_XFER   = 2'd3
    } lcd_mode_e;

    logic [7:0]        lcdc_q, lcdc_d;
    logic [3:0]        stat_q, stat_d;      // STAT bits 6:3
    logic [7:0]        lyc_q, lyc_d;
    logic [7:0]        do_q, do_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DOT_W-1:0]  pixel_q, pixel_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [3:0]        xlen_q, xlen_d;
    logic              vblank_prev_q, vblank_prev_d;
    logic              vblank_req_q, vblank_req_d;
    logic              lcdc_req_q, lcdc_req_d;
`ifdef PPU_STAT_BLOCKING_EN
    logic              stat_prev_q, stat_prev_d;
`else
    logic [3:0]        stat_prev_q, stat_prev_d;
`endif

    logic       rd_en, wr_en, ly_wr;
    logic       lcd_on, lcd_run, dot_tick;
    logic       coincidence, vblank_cond, stat_set;
    logic [3:0] stat_src;
    lcd_mode_e  mode_c;

    assign rd_en    = cs && !rd_n;
    assign wr_en    = cs && !wr_n && rd_n;
    assign ly_wr    = wr_en && (A == ADDR_LY);
    assign lcd_on   = lcdc_q[7];
    // Counters advance only while the LCD was on and stays on; an enabling write starts them next clock.
    assign lcd_run  = lcd_on && lcdc_d[7];
    assign dot_tick = lcd_on && (div_q == DIV_W'(DIV - 1));

    always_comb begin
        mode_c = MODE_HBLANK;
        if (!lcd_on)
            mode_c = MODE_HBLANK;
        else if (int'(line_q) >= VACTIVE)
            mode_c = MODE_VBLANK;
        else if (int'(pixel_q) < OAM_DOTS)
            mode_c = MODE_OAM;
        else if (int'(pixel_q) < OAM_DOTS + XFER_DOTS + int'(xlen_q))
            mode_c = MODE_XFER;
        else
            mode_c = MODE_HBLANK;
    end

    assign coincidence = lcd_on && (int'(line_q) == int'(lyc_q));
    assign vblank_cond = lcd_on && (int'(line_q) == VACTIVE);
    assign stat_src    = {stat_q[3] & coincidence,
                          stat_q[2] & (mode_c == MODE_OAM),
                          stat_q[1] & (mode_c == MODE_VBLANK),
                          stat_q[0] & (mode_c == MODE_HBLANK) & lcd_on};

    // NOTE: every signal gets a default before any branch, so no path leaves it unassigned (no latch).
    always_comb begin
        lcdc_d = lcdc_q;
        stat_d = stat_q;
        lyc_d  = lyc_q;
        if (wr_en) begin
            case (A)
                ADDR_LCDC: lcdc_d = Di;
                ADDR_STAT: stat_d = Di[6:3];
                ADDR_LYC:  lyc_d  = Di;
                default:   ;
            endcase
        end

        do_d = do_q;
        if (rd_en) begin
            case (A)
                ADDR_LCDC: do_d = lcdc_q;
                ADDR_STAT: do_d = {1'b1, stat_q, coincidence, mode_c};
                ADDR_LY:   do_d = 8'(line_q);
                ADDR_LYC:  do_d = lyc_q;
                default:   do_d = 8'hFF;
            endcase
        end
    end

    always_comb begin
        div_d   = div_q;
        pixel_d = pixel_q;
        line_d  = line_q;
        xlen_d  = xlen_q;
        if (!lcd_run) begin
            div_d   = '0;
            pixel_d = '0;
            line_d  = '0;
            xlen_d  = '0;
        end else if (ly_wr) begin
            div_d   = '0;
            pixel_d = '0;
            line_d  = '0;
        end else if (dot_tick) begin
            div_d = '0;
            if (pixel_q == DOT_W'(OAM_DOTS - 1))
                xlen_d = xfer_extra;
            if (pixel_q == DOT_W'(PIXELS - 1)) begin
                pixel_d = '0;
                line_d  = (line_q == LINE_W'(LINES - 1)) ? '0 : line_q + 1'b1;
            end else begin
                pixel_d = pixel_q + 1'b1;
            end
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_comb begin
        vblank_prev_d = vblank_cond;
`ifdef PPU_STAT_BLOCKING_EN
        stat_prev_d   = |stat_src;
        stat_set      = (|stat_src) && !stat_prev_q;
`else
        stat_prev_d   = stat_src;
        stat_set      = |(stat_src & ~stat_prev_q);
`endif
        // A new set takes priority over an acknowledge arriving in the same cycle.
        vblank_req_d  = (vblank_cond && !vblank_prev_q) || (vblank_req_q && !int_vblank_ack);
        lcdc_req_d    = stat_set || (lcdc_req_q && !int_lcdc_ack);
    end

    // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lcdc_q        <= '0;
            stat_q        <= '0;
            lyc_q         <= '0;
            do_q          <= 8'hFF;
            div_q         <= '0;
            pixel_q       <= '0;
            line_q        <= '0;
            xlen_q        <= '0;
            vblank_prev_q <= 1'b0;
            stat_prev_q   <= '0;
            vblank_req_q  <= 1'b0;
            lcdc_req_q    <= 1'b0;
        end else begin
            lcdc_q        <= lcdc_d;
            stat_q        <= stat_d;
            lyc_q         <= lyc_d;
            do_q          <= do_d;
            div_q         <= div_d;
            pixel_q       <= pixel_d;
            line_q        <= line_d;
            xlen_q        <= xlen_d;
            vblank_prev_q <= vblank_prev_d;
            stat_prev_q   <= stat_prev_d;
            vblank_req_q  <= vblank_req_d;
            lcdc_req_q    <= lcdc_req_d;
        end
    end

    assign Do             = do_q;
    assign dot_en         = dot_tick;
    assign line_count     = line_q;
    assign pixel_count    = pixel_q;
    assign mode           = mode_c;
    assign oam_lock       = (mode_c == MODE_OAM) || (mode_c == MODE_XFER);
    assign vram_lock      = (mode_c == MODE_XFER);
    assign int_vblank_req = vblank_req_q;
    assign int_lcdc_req   = lcdc_req_q;

endmodule
